ppu_vga_line_buffer: RTL and testbench

PPU_VGA_LINE_BUFFER -- requirements
Module: ppu_vga_line_buffer

---
 rtl/ppu_vga_pkg.sv | 48 ++++
 rtl/ppu_vga_line_buffer_if.sv | 26 ++
 rtl/ppu_line_ram.sv | 29 ++
 rtl/ppu_vga_line_buffer.sv | 117 +++++++++++
 tb/tb_ppu_vga_line_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_vga_pkg.sv
// Shared VGA timing constants, pipeline control bundle and the NES RGB palette.
package ppu_vga_pkg;

    // 640x480@60 timing, in pixel ticks (horizontal) and lines (vertical).
    localparam logic [9:0] H_VIS     = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_TOT     = 10'd800;
    localparam logic [9:0] V_VIS     = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_TOT     = 10'd525;
    localparam logic [9:0] NES_X_OFF = 10'd64;

    localparam logic [9:0] H_SYNC_BEG = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END = H_VIS + H_FP + H_SYNC;
    localparam logic [9:0] V_SYNC_BEG = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END = V_VIS + V_FP + V_SYNC;
    // 256 NES pixels doubled horizontally.
    localparam logic [9:0] NES_X_END  = NES_X_OFF + 10'd512;
    // Scanlines at or above this are PPU vblank lines and never stored.
    localparam logic [7:0] NES_LINES  = 8'd240;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic window;
    } vga_ctl_t;

    localparam vga_ctl_t VGA_CTL_RST = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1, window: 1'b0};

    localparam logic [23:0] NES_PAL [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    function automatic logic [23:0] nes_rgb(input logic [5:0] idx);
        return NES_PAL[idx];
    endfunction

endpackage

// File: rtl/ppu_vga_line_buffer_if.sv
// PPU pixel write bus and VGA output bundle.
interface ppu_vga_line_buffer_if;
    logic       pix_valid;
    logic [7:0] pix_color;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_blank;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       overrun_err;

    // master: PPU side plus VGA sink
    modport master (
        output pix_valid, pix_color, pix_x, pix_y,
        input  vga_hsync, vga_vsync, vga_blank, vga_r, vga_g, vga_b, overrun_err
    );

    // slave: the line buffer
    modport slave (
        input  pix_valid, pix_color, pix_x, pix_y,
        output vga_hsync, vga_vsync, vga_blank, vga_r, vga_g, vga_b, overrun_err
    );
endinterface

// File: rtl/ppu_line_ram.sv
// Two 256x6 line banks: one write port, one registered read port (read-before-write).
module ppu_line_ram (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic       wbank_i,
    input  logic [7:0] waddr_i,
    input  logic [5:0] wdata_i,
    input  logic       re_i,
    input  logic       rbank_i,
    input  logic [7:0] raddr_i,
    output logic [5:0] rdata_o
);
    logic [5:0] mem_q [2][256];
    logic [5:0] rdata_q, rdata_d;

    // Hold the last read value between pixel ticks.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[rbank_i][raddr_i];
    end

    // Storage is intentionally not reset; a colliding read sees the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ppu_vga_line_buffer.sv
// PPU scanline double-buffer scanned out as 2x2-replicated 640x480 VGA.
module ppu_vga_line_buffer
    import ppu_vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ppu_vga_line_buffer_if.slave bus
);
    logic        tick_q, tick_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    vga_ctl_t    s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
    logic [23:0] rgb_q, rgb_d;
    logic        ovr_q, ovr_d;

    logic        pix_tick, visible, in_window, wr_en, rd_bank;
    logic [7:0]  nes_x;
    logic [5:0]  rd_color;
    logic        unused_color_hi;

    assign pix_tick        = tick_q;
    assign unused_color_hi = ^bus.pix_color[7:6];

    // Pixel tick toggle and raster counters.
    always_comb begin
        tick_d = ~tick_q;
        h_d    = h_q;
        v_d    = v_q;
        if (pix_tick) begin
            if (h_q == H_TOT - 10'd1) begin
                h_d = '0;
                v_d = (v_q == V_TOT - 10'd1) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Raster decode and write qualification.
    always_comb begin
        visible   = (h_q < H_VIS) && (v_q < V_VIS);
        in_window = visible && (h_q >= NES_X_OFF) && (h_q < NES_X_END);
        nes_x     = 8'((h_q - NES_X_OFF) >> 1);
        rd_bank   = v_q[1];  // nes_y[0]
        wr_en     = bus.pix_valid && (bus.pix_y < NES_LINES);
    end

    ppu_line_ram u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .wbank_i (bus.pix_y[0]),
        .waddr_i (bus.pix_x),
        .wdata_i (bus.pix_color[5:0]),
        .re_i    (pix_tick),
        .rbank_i (rd_bank),
        .raddr_i (nes_x),
        .rdata_o (rd_color)
    );

    // Stage 1 tracks the RAM read; stage 2 does the palette lookup. Overrun is sticky.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        blank_d    = blank_q;
        rgb_d      = rgb_q;
        if (pix_tick) begin
            s1_d.hsync  = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
            s1_d.vsync  = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
            s1_d.blank  = !visible;
            s1_d.window = in_window;
            s1_valid_d  = 1'b1;
            hsync_d     = s1_q.hsync;
            vsync_d     = s1_q.vsync;
            blank_d     = s1_q.blank;
            rgb_d       = (s1_valid_q && s1_q.window) ? nes_rgb(rd_color) : '0;
        end
        ovr_d = ovr_q | (wr_en && visible && (bus.pix_y[0] == rd_bank));
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            s1_q       <= VGA_CTL_RST;
            s1_valid_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b1;
            rgb_q      <= '0;
            ovr_q      <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            h_q        <= h_d;
            v_q        <= v_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            blank_q    <= blank_d;
            rgb_q      <= rgb_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.vga_blank   = blank_q;
    assign bus.vga_r       = rgb_q[23:16];
    assign bus.vga_g       = rgb_q[15:8];
    assign bus.vga_b       = rgb_q[7:0];
    assign bus.overrun_err = ovr_q;
endmodule

// File: tb/tb_ppu_vga_line_buffer.sv
// Randomized bench for ppu_vga_line_buffer against a raster-position reference model.
module tb_ppu_vga_line_buffer;
    import ppu_vga_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ppu_vga_line_buffer_if bus ();

    ppu_vga_line_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: k = clk edges since reset release; pixel ticks = k/2.
    int unsigned k = 0;
    bit          ovr_m = 1'b0;
    logic [5:0]  mem_m   [2][256];
    bit          known_m [2][256];
    logic [5:0]  col_hist   [4];
    bit          known_hist [4];

    // hsync edge monitor
    bit          prev_hs   = 1'b1;
    bit          fall_seen = 1'b0;
    int unsigned last_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, k);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hsync"}, 32'(bus.vga_hsync), 32'd1);
        check({tag, "_vsync"}, 32'(bus.vga_vsync), 32'd1);
        check({tag, "_blank"}, 32'(bus.vga_blank), 32'd1);
        check({tag, "_rgb"}, {8'd0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'd0);
        check({tag, "_overrun"}, 32'(bus.overrun_err), 32'd0);
    endtask

    // Advance the model across one rising clk edge, using the inputs the DUT samples there.
    task automatic model_edge();
        int unsigned cp, h, v, bank, nx;
        bit vis, win;
        cp   = k / 2;
        h    = cp % 800;
        v    = (cp / 800) % 525;
        bank = (v / 2) % 2;
        vis  = (h < 640) && (v < 480);
        win  = vis && (h >= 64) && (h < 576);
        if (bus.pix_valid && bus.pix_y < 240 && vis && (bus.pix_y % 2) == bank) ovr_m = 1'b1;
        if (k % 2 == 1) begin
            nx = (h >= 64) ? (h - 64) / 2 : 0;
            known_hist[cp % 4] = win && known_m[bank][nx % 256];
            col_hist[cp % 4]   = mem_m[bank][nx % 256];
        end
        if (bus.pix_valid && bus.pix_y < 240) begin
            mem_m[bus.pix_y % 2][bus.pix_x]   = bus.pix_color[5:0];
            known_m[bus.pix_y % 2][bus.pix_x] = 1'b1;
        end
        k++;
    endtask

    task automatic compare();
        int unsigned p, q, h, v;
        logic        e_hs, e_vs, e_bl;
        logic [23:0] e_rgb, a_rgb;
        bit          rgb_known;
        a_rgb = {bus.vga_r, bus.vga_g, bus.vga_b};
        if (rst) begin
            check_reset("in_reset");
            return;
        end
        p = k / 2;
        h = 0;
        v = 0;
        if (p < 2) begin
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_rgb = '0; rgb_known = 1'b1;
        end else begin
            q     = p - 2;
            h     = q % 800;
            v     = (q / 800) % 525;
            e_bl  = !((h < 640) && (v < 480));
            e_hs  = !((h >= 656) && (h < 752));
            e_vs  = !((v >= 490) && (v < 492));
            if (!e_bl && h >= 64 && h < 576) begin
                rgb_known = known_hist[q % 4];
                e_rgb     = NES_PAL[col_hist[q % 4]];
            end else begin
                rgb_known = 1'b1;
                e_rgb     = '0;
            end
        end
        check("hsync", 32'(bus.vga_hsync), 32'(e_hs));
        check("vsync", 32'(bus.vga_vsync), 32'(e_vs));
        check("blank", 32'(bus.vga_blank), 32'(e_bl));
        if (rgb_known) check("rgb", {8'd0, a_rgb}, {8'd0, e_rgb});
        check("overrun", 32'(bus.overrun_err), 32'(ovr_m));

        // Hand-computed pins.
        if (p >= 2) begin
            if ((v == 1 || v == 4 || v == 5) && h >= 64 && h <= 67)
                check("pin_replicate", {8'd0, a_rgb}, (h < 66) ? 32'hFCFCFC : 32'h7C7C7C);
            if (v < 480 && (h == 0 || h == 63 || h == 576 || h == 639)) begin
                check("pin_border_rgb", {8'd0, a_rgb}, 32'd0);
                check("pin_border_blank", 32'(bus.vga_blank), 32'd0);
            end
            if (h == 640 || h == 799) begin
                check("pin_hblank_rgb", {8'd0, a_rgb}, 32'd0);
                check("pin_hblank_blank", 32'(bus.vga_blank), 32'd1);
            end
            if (h == 0 && v == 7) check("pin_overrun_clear", 32'(bus.overrun_err), 32'd0);
            if (h == 0 && v == 9) check("pin_overrun_set", 32'(bus.overrun_err), 32'd1);
        end

        if (prev_hs && !bus.vga_hsync) begin
            if (!fall_seen) check("first_hsync_fall_clk", k, 32'd1316);
            else            check("hsync_period_clk", k - last_fall, 32'd1600);
            fall_seen = 1'b1;
            last_fall = k;
        end else if (!prev_hs && bus.vga_hsync && fall_seen) begin
            check("hsync_low_clk", k - last_fall, 32'd192);
        end
        prev_hs = bus.vga_hsync;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive_idle();
        bus.pix_valid = 1'b0;
        bus.pix_color = 8'd0;
        bus.pix_x     = 8'd0;
        bus.pix_y     = 8'd0;
    endtask

    // Random writes; stored lines always target the bank not on screen.
    task automatic drive_random();
        int unsigned cp, v, bank;
        cp   = k / 2;
        v    = (cp / 800) % 525;
        bank = (v / 2) % 2;
        bus.pix_valid = 1'($urandom_range(0, 1));
        bus.pix_color = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            bus.pix_y = 8'(240 + $urandom_range(0, 15));
            bus.pix_x = 8'($urandom);
        end else begin
            bus.pix_y = 8'(2 * $urandom_range(0, 119) + (1 - bank));
            bus.pix_x = 8'($urandom_range(2, 255));
        end
    endtask

    task automatic do_reset_model();
        k         = 0;
        ovr_m     = 1'b0;
        prev_hs   = 1'b1;
        fall_seen = 1'b0;
        last_fall = 0;
    endtask

    initial begin
        bit ign_done, ovr_done;
        int unsigned cp, h, v;
        ign_done = 1'b0;
        ovr_done = 1'b0;
        drive_idle();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) begin
                known_m[b][a] = 1'b0;
                mem_m[b][a]   = 6'd0;
            end
        for (int i = 0; i < 4; i++) begin
            known_hist[i] = 1'b0;
            col_hist[i]   = 6'd0;
        end

        repeat (4) step_cycle();
        rst = 1'b0;

        // Fill NES line 0 during the horizontal blank of VGA line 0.
        while (k < 1282) step_cycle();
        for (int x = 0; x < 256; x++) begin
            bus.pix_valid = 1'b1;
            bus.pix_y     = 8'd0;
            bus.pix_x     = 8'(x);
            bus.pix_color = (x % 2 == 0) ? 8'hF0 : 8'hC0;  // upper bits must be ignored
            step_cycle();
        end

        // Random traffic with a directed ignored-line write and a directed overrun.
        forever begin
            cp = k / 2;
            h  = cp % 800;
            v  = (cp / 800) % 525;
            if (v >= 20 && h >= 300) break;
            if (!ign_done && v == 4 && h >= 100) begin
                bus.pix_valid = 1'b1;
                bus.pix_y     = 8'd240;
                bus.pix_x     = 8'd0;
                bus.pix_color = 8'h16;
                ign_done      = 1'b1;
            end else if (!ovr_done && v == 8 && h >= 100) begin
                bus.pix_valid = 1'b1;
                bus.pix_y     = 8'd4;
                bus.pix_x     = 8'd100;
                bus.pix_color = 8'h21;
                ovr_done      = 1'b1;
            end else begin
                drive_random();
            end
            step_cycle();
        end

        // Asynchronous reset mid-frame: outputs must return before the next clk edge.
        #2 rst = 1'b1;
        #1 check_reset("async_reset");
        do_reset_model();
        drive_idle();
        repeat (3) step_cycle();
        rst = 1'b0;

        while (k < 6 * 1600) begin
            drive_random();
            step_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
